// File: rtl/mpadder_pkg.sv
// Shared types for the multi-precision adder arbiter: operand width,
// FSM state encoding and requester id.
package mpadder_pkg;

  localparam int MP_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request grant picker producing a one-hot grant.
// MPADDER_ARB_RR_EN selects round-robin; otherwise requester 0 wins ties.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef MPADDER_ARB_RR_EN
  // ptr_reg = 0 favours requester 0 on a tie, 1 favours requester 1.
  logic ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (accept && (gnt != 2'b00)) begin
      ptr_reg <= gnt[0];
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_reg ? 2'b10 : 2'b01;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, accept};

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/mpadder_arbiter.sv
// Shares one start/done multi-precision adder between two requesters.
// Tie-breaking is round-robin when MPADDER_ARB_RR_EN is defined, else fixed priority.
module mpadder_arbiter
  import mpadder_pkg::*;
#(
  parameter int WIDTH = MP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH:0]   rsp_c,
  output logic             add_start,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_c,
  input  logic             add_done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH:0]   c_reg;
  owner_t           owner_reg;
  logic [1:0]       gnt;
  logic             accept;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  // Requests are only considered in IDLE and never while reset is held.
  assign accept = (state_reg == IDLE) && !rst && (gnt != 2'b00);

  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    add_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = accept && gnt[0];
        req1_ready = accept && gnt[1];
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        add_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (add_done) state_next = RESP;
      end
      RESP: begin
        rsp0_valid = (owner_reg == 1'b0);
        rsp1_valid = (owner_reg == 1'b1);
        if ((owner_reg == 1'b0 && rsp0_ready) || (owner_reg == 1'b1 && rsp1_ready)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      owner_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= gnt[1] ? req1_a : req0_a;
        b_reg     <= gnt[1] ? req1_b : req0_b;
        owner_reg <= gnt[1];
      end
      if (state_reg == WAIT && add_done) begin
        c_reg <= add_c;
      end
    end
  end

  assign add_a = a_reg;
  assign add_b = b_reg;
  assign rsp_c = c_reg;

endmodule
